// File: rtl/atari7800_pkg.sv
// Shared Atari 7800 definitions: bus arbiter state encoding and default timing
// constants for the SALLY / MARIA bus hand-over.
package atari7800_pkg;

    // Arbiter states; the encoding is exposed on state_dbg, so keep it fixed.
    typedef enum logic [1:0] {
        ARB_CPU     = 2'd0,
        ARB_HALTING = 2'd1,
        ARB_DMA     = 2'd2,
        ARB_TURN    = 2'd3
    } arb_state_t;

    // pclk0 ticks between HALT going low and the CPU being considered off the bus.
    localparam int HALT_LAT_DEF = 2;

    // sysclock cycles of bus turnaround after a DMA window.
    localparam int TURN_CYC_DEF = 1;

    // Longest DMA grant in sysclock cycles before the watchdog takes the bus back.
    localparam int MAX_DMA_DEF = 511;

    // Watchdog counter width; must satisfy 2**CW > MAX_DMA.
    localparam int CW_DEF = 9;

    // Cycle-count parameters of zero are treated as one, so every wait state
    // lasts at least one cycle.
    function automatic int at_least_one(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/maria_bus_arbiter_if.sv
// Control signals between the bus arbiter and its surroundings: the CPU core
// (halt_b/rdy), memory_map (drive_AB, WSYNC pulse) and the MARIA DMA engine.
interface maria_bus_arbiter_if;

    logic       pclk0;
    logic       deassert_ready;
    logic       line_start;
    logic       dma_en;
    logic       dma_req;
    logic       dma_done;

    logic       halt_b;
    logic       rdy;
    logic       drive_AB;
    logic       dma_grant;
    logic       dma_timeout;
    logic [1:0] state_dbg;

    // The arbiter itself: takes requests and timing strobes, drives bus ownership.
    modport slave (
        input  pclk0,
        input  deassert_ready,
        input  line_start,
        input  dma_en,
        input  dma_req,
        input  dma_done,
        output halt_b,
        output rdy,
        output drive_AB,
        output dma_grant,
        output dma_timeout,
        output state_dbg
    );

    // The environment around the arbiter: raises requests, observes ownership.
    modport master (
        output pclk0,
        output deassert_ready,
        output line_start,
        output dma_en,
        output dma_req,
        output dma_done,
        input  halt_b,
        input  rdy,
        input  drive_AB,
        input  dma_grant,
        input  dma_timeout,
        input  state_dbg
    );

endinterface

// File: rtl/maria_bus_arbiter.sv
// Shared system bus arbiter between SALLY (6502) and MARIA DMA.
// Each DMA request runs CPU -> HALTING -> DMA -> TURN -> CPU, so there is always
// a turnaround cycle before the CPU gets the bus back. The WSYNC ready stall runs
// alongside the arbiter and only affects rdy.
module maria_bus_arbiter
    import atari7800_pkg::*;
#(
    parameter int HALT_LAT = HALT_LAT_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF,
    parameter int MAX_DMA  = MAX_DMA_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                  sysclock,
    input  logic                  reset_b,
    maria_bus_arbiter_if.slave    bus
);

    // Zero-length parameters become one cycle, so every state has a defined exit.
    localparam int HALT_EFF = at_least_one(HALT_LAT);
    localparam int TURN_EFF = at_least_one(TURN_CYC);
    localparam int MAX_EFF  = at_least_one(MAX_DMA);

    localparam int HW = $clog2(HALT_EFF + 1);
    localparam int TW = $clog2(TURN_EFF + 1);

    localparam logic [HW-1:0] HALT_LAST = HW'(HALT_EFF - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_EFF - 1);
    localparam logic [CW-1:0] WD_LAST   = CW'(MAX_EFF - 1);
    localparam logic [CW-1:0] WD_MAX    = CW'(MAX_EFF);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [HW-1:0] halt_cnt;
    logic [TW-1:0] turn_cnt;
    logic [CW-1:0] wd_cnt;
    logic          wd_fire;
    logic          stall;
    logic          timeout_flag;

    // Next-state decode: request qualification, halt latency, DMA end or watchdog, turnaround.
    always_comb begin
        state_next = state;
        wd_fire    = 1'b0;
        case (state)
            ARB_CPU: begin
                if (bus.dma_req && bus.dma_en) begin
                    state_next = ARB_HALTING;
                end
            end
            ARB_HALTING: begin
                if (!bus.dma_req) begin
                    state_next = ARB_TURN;
                end else if (bus.pclk0 && (halt_cnt == HALT_LAST)) begin
                    state_next = ARB_DMA;
                end
            end
            ARB_DMA: begin
                if (bus.dma_done) begin
                    state_next = ARB_TURN;
                end else if (wd_cnt == WD_LAST) begin
                    state_next = ARB_TURN;
                    wd_fire    = 1'b1;
                end
            end
            ARB_TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_next = ARB_CPU;
                end
            end
            default: begin
                state_next = ARB_CPU;
            end
        endcase
    end

    // State register plus halt/turn/watchdog counters, WSYNC stall and sticky timeout.
    always_ff @(posedge sysclock or negedge reset_b) begin
        if (!reset_b) begin
            state        <= ARB_CPU;
            halt_cnt     <= '0;
            turn_cnt     <= '0;
            wd_cnt       <= '0;
            stall        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_next;

            if (state == ARB_HALTING && state_next == ARB_HALTING) begin
                if (bus.pclk0) begin
                    halt_cnt <= halt_cnt + 1'b1;
                end
            end else begin
                halt_cnt <= '0;
            end

            if (state == ARB_TURN && state_next == ARB_TURN) begin
                turn_cnt <= turn_cnt + 1'b1;
            end else begin
                turn_cnt <= '0;
            end

            if (state == ARB_DMA && state_next == ARB_DMA) begin
                if (wd_cnt != WD_MAX) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end

            if (wd_fire) begin
                timeout_flag <= 1'b1;
            end

            if (bus.pclk0 && bus.deassert_ready) begin
                stall <= 1'b1;
            end else if (bus.line_start) begin
                stall <= 1'b0;
            end
        end
    end

    // Outputs decode straight from flops, so every one is a registered value.
    assign bus.halt_b      = (state == ARB_CPU);
    assign bus.drive_AB    = (state == ARB_DMA);
    assign bus.dma_grant   = (state == ARB_DMA);
    assign bus.rdy         = ~stall;
    assign bus.dma_timeout = timeout_flag;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Directed bench for maria_bus_arbiter. Stimulus pushes the expected output
// vector for a given cycle into a queue; a monitor on the falling edge pops and
// compares everything due for the current cycle.
module tb_maria_bus_arbiter;

    logic sysclock;
    logic reset_b;
    int   cyc;
    int   checks;
    int   errors;

    // Output vector layout: {halt_b, rdy, drive_AB, dma_grant, dma_timeout, state_dbg[1:0]}
    typedef struct {
        int         cycle;
        string      name;
        logic [6:0] val;
        logic [6:0] mask;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [6:0] M_ALL = 7'b1111111;
    localparam logic [6:0] M_RDY = 7'b0100000;
    localparam logic [6:0] M_ARB = 7'b1011111;

    maria_bus_arbiter_if bus ();

    maria_bus_arbiter dut (
        .sysclock (sysclock),
        .reset_b  (reset_b),
        .bus      (bus)
    );

    // 10 ns system clock.
    initial sysclock = 1'b0;
    always #5 sysclock = ~sysclock;

    // Cycle index used to time-stamp expectations.
    initial cyc = 0;
    always @(posedge sysclock) cyc <= cyc + 1;

    function automatic logic [6:0] vec(input logic halt, input logic rdy, input logic drv,
                                       input logic to, input logic [1:0] st);
        return {halt, rdy, drv, drv, to, st};
    endfunction

    task automatic tick();
        @(posedge sysclock);
        #1;
    endtask

    task automatic expect_at(input int dly, input string name, input logic [6:0] val,
                             input logic [6:0] mask);
        exp_t e;
        e.cycle = cyc + dly;
        e.name  = name;
        e.val   = val;
        e.mask  = mask;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic p, input logic dr, input logic ls,
                                  input logic en, input logic rq, input logic dn);
        bus.pclk0          = p;
        bus.deassert_ready = dr;
        bus.line_start     = ls;
        bus.dma_en         = en;
        bus.dma_req        = rq;
        bus.dma_done       = dn;
    endtask

    task automatic check_output(input exp_t e);
        logic [6:0] act;
        act = {bus.halt_b, bus.rdy, bus.drive_AB, bus.dma_grant, bus.dma_timeout, bus.state_dbg};
        checks++;
        if (e.cycle != cyc) begin
            errors++;
            $display("[TB] FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cycle, cyc);
        end else if ((act & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got %b, expected %b (mask %b)",
                     e.name, cyc, act, e.val, e.mask);
        end
    endtask

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge sysclock) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cycle <= cyc) begin
            e = exp_q.pop_front();
            check_output(e);
        end
    end

    // Full DMA with three grant cycles; to is the expected sticky timeout value.
    task automatic basic_dma(input logic to);
        apply_stimulus(0, 0, 0, 1, 1, 0);
        expect_at(1, "halt_low_next", vec(0, 1, 0, to, 2'd1), M_ALL);
        tick();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus((i % 4) == 3, 0, 0, 1, 1, 0);
            expect_at(0, "halting_no_grant", vec(0, 1, 0, to, 2'd1), M_ALL);
            tick();
        end
        apply_stimulus(0, 0, 0, 1, 1, 0);
        expect_at(0, "grant_after_2nd_pclk0", vec(0, 1, 1, to, 2'd2), M_ALL);
        tick();
        expect_at(0, "grant_held", vec(0, 1, 1, to, 2'd2), M_ALL);
        tick();
        apply_stimulus(0, 0, 0, 1, 0, 1);
        expect_at(0, "grant_last", vec(0, 1, 1, to, 2'd2), M_ALL);
        tick();
        apply_stimulus(0, 0, 0, 1, 0, 0);
        expect_at(0, "turn_bus_free", vec(0, 1, 0, to, 2'd3), M_ALL);
        tick();
        expect_at(0, "cpu_resume", vec(1, 1, 0, to, 2'd0), M_ALL);
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_b = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        expect_at(0, "reset_state", vec(1, 1, 0, 0, 2'd0), M_ALL);
        tick();
        reset_b = 1'b1;
        tick();

        // Basic DMA hand-over.
        basic_dma(1'b0);

        // Request with DMA disabled must never halt the CPU.
        for (int i = 0; i < 100; i++) begin
            apply_stimulus((i % 4) == 0, 0, 0, 0, 1, 0);
            expect_at(0, "dma_disabled", vec(1, 1, 0, 0, 2'd0), M_ALL);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        expect_at(0, "dma_disabled_end", vec(1, 1, 0, 0, 2'd0), M_ALL);
        tick();

        // WSYNC stall: pulse without pclk0 is ignored, then a qualified set and a clear.
        apply_stimulus(0, 1, 0, 0, 0, 0);
        expect_at(1, "wsync_needs_pclk0", vec(1, 1, 0, 0, 2'd0), M_RDY);
        tick();
        apply_stimulus(1, 1, 0, 0, 0, 0);
        expect_at(1, "rdy_low", vec(1, 0, 0, 0, 2'd0), M_RDY);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            expect_at(0, "rdy_held", vec(1, 0, 0, 0, 2'd0), M_RDY);
            tick();
        end
        apply_stimulus(0, 0, 1, 0, 0, 0);
        expect_at(0, "rdy_low_at_line_start", vec(1, 0, 0, 0, 2'd0), M_RDY);
        expect_at(1, "rdy_release", vec(1, 1, 0, 0, 2'd0), M_RDY);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();

        // Set and clear in the same cycle: set wins.
        apply_stimulus(1, 1, 1, 0, 0, 0);
        expect_at(1, "set_wins", vec(1, 0, 0, 0, 2'd0), M_RDY);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            expect_at(0, "set_wins_hold", vec(1, 0, 0, 0, 2'd0), M_RDY);
            tick();
        end
        apply_stimulus(0, 0, 1, 0, 0, 0);
        expect_at(1, "rdy_release2", vec(1, 1, 0, 0, 2'd0), M_RDY);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();

        // Abort: request drops during HALTING.
        apply_stimulus(0, 0, 0, 1, 1, 0);
        expect_at(1, "abort_halting", vec(0, 1, 0, 0, 2'd1), M_ALL);
        tick();
        apply_stimulus(1, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 1, 0, 0);
        expect_at(0, "abort_still_halting", vec(0, 1, 0, 0, 2'd1), M_ALL);
        tick();
        expect_at(0, "abort_turn", vec(0, 1, 0, 0, 2'd3), M_ALL);
        tick();
        expect_at(0, "abort_cpu", vec(1, 1, 0, 0, 2'd0), M_ALL);
        tick();
        expect_at(0, "abort_cpu_stays", vec(1, 1, 0, 0, 2'd0), M_ALL);
        tick();

        // Watchdog: grant without dma_done lasts 511 cycles and sets the sticky flag.
        apply_stimulus(0, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(1, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(1, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 511; i++) begin
            if (i == 0) begin
                expect_at(0, "wd_grant_first", vec(0, 1, 1, 0, 2'd2), M_ALL);
            end
            if (i == 510) begin
                expect_at(0, "wd_grant_last", vec(0, 1, 1, 0, 2'd2), M_ALL);
                apply_stimulus(0, 0, 0, 1, 0, 0);
            end
            tick();
        end
        expect_at(0, "wd_release", vec(0, 1, 0, 1, 2'd3), M_ALL);
        tick();
        expect_at(0, "wd_cpu_sticky", vec(1, 1, 0, 1, 2'd0), M_ALL);
        tick();

        // A normal DMA afterwards keeps the timeout flag set.
        basic_dma(1'b1);

        // Back-to-back: request held through TURN gives exactly one CPU cycle.
        apply_stimulus(0, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(1, 0, 0, 1, 1, 0);
        expect_at(0, "b2b_halting", vec(0, 1, 0, 1, 2'd1), M_ARB);
        tick();
        tick();
        apply_stimulus(0, 0, 0, 1, 1, 1);
        expect_at(0, "b2b_grant", vec(0, 1, 1, 1, 2'd2), M_ALL);
        tick();
        apply_stimulus(0, 0, 0, 1, 1, 0);
        expect_at(0, "b2b_turn", vec(0, 1, 0, 1, 2'd3), M_ALL);
        tick();
        expect_at(0, "b2b_cpu_one_cycle", vec(1, 1, 0, 1, 2'd0), M_ALL);
        tick();
        apply_stimulus(0, 0, 0, 1, 0, 0);
        expect_at(0, "b2b_rehalt", vec(0, 1, 0, 1, 2'd1), M_ALL);
        tick();
        expect_at(0, "b2b_abort_turn", vec(0, 1, 0, 1, 2'd3), M_ALL);
        tick();
        expect_at(0, "b2b_abort_cpu", vec(1, 1, 0, 1, 2'd0), M_ALL);
        tick();

        // Reset mid-DMA with a WSYNC stall active returns everything at once.
        apply_stimulus(0, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(1, 1, 0, 1, 1, 0);
        tick();
        apply_stimulus(1, 0, 0, 1, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 1, 1, 0);
        expect_at(0, "pre_reset_dma", vec(0, 0, 1, 1, 2'd2), M_ALL);
        tick();
        reset_b = 1'b0;
        expect_at(0, "reset_mid_dma", vec(1, 1, 0, 0, 2'd0), M_ALL);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        reset_b = 1'b1;
        expect_at(1, "after_reset", vec(1, 1, 0, 0, 2'd0), M_ALL);
        tick();
        tick();
        tick();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation for cycle %0d never compared", e.name, e.cycle);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
